jitter_clk_gen: RTL
===================

// Module: jitter_clk_gen
// PURPOSE
//  Synthesisable, multi-channel successor to the behavioural forever-loop clock generator.
//  Produces N_CH divided clock/enable waveforms from one system clock.
//  Each channel has a programmable half-period plus bounded pseudo-random jitter from a shared LFSR.
//  Start/stop is per channel and glitch-free. Sits in test/stimulus infrastructure and feeds DUT clock-enables.
// PARAMETERS
//  N_CH    4        number of output channels
//  CNT_W   8        half-period counter / jitter width (bits)
//  LFSR_W  16       LFSR width, must be >= CNT_W
//  SEED    16'hACE1 LFSR reset value; nonzero; also substituted when seed==0 is loaded
// PORTS
//  clk          in   1           system clock, all logic on rising edge
//  rst_n        in   1           asynchronous active-low reset
//  ch_en        in   N_CH        per-channel enable (level)
//  half_period  in   N_CH*CNT_W  base half-period per channel, ch i at [i*CNT_W +: CNT_W]
//  jitter_mask  in   CNT_W       AND-mask applied to random value (shared by all channels)
//  seed_load    in   1           load seed into LFSR this cycle
//  seed         in   LFSR_W      LFSR load value
//  clk_out      out  N_CH        generated waveforms
//  toggle_pls   out  N_CH        1-cycle pulse in the cycle after clk_out[i] changes
//  running      out  N_CH        1 while channel is in RUN or STOPPING
// BEHAVIOUR
//  Reset: lfsr=SEED; per channel state=IDLE, cnt=0, clk_out=0, toggle_pls=0, running=0.
//  LFSR:
//   - Galois, taps 16'hB400 (x^16+x^14+x^13+x^11+1) for LFSR_W=16.
//   - Shifts every cycle, including while all channels are idle.
//   - seed_load=1 loads seed (SEED if seed==0) instead of shifting; seed_load takes priority.
//  Random value for channel i: r_i = low CNT_W bits of lfsr rotated left by 3*i.
//  Reload: L_i = half_period_i + (r_i & jitter_mask), saturating at 2^CNT_W-1.
//   - half_period is sampled only when a reload happens.
//  Toggle timing:
//   - Counter loaded with L and decremented each cycle.
//   - At cnt==0 while in RUN/STOPPING: clk_out flips, L reloads, toggle_pls=1 next cycle.
//   - Interval between flips is L+1 cycles. half_period=0, mask=0 gives clk/2.
//  Channel FSM:
//   - IDLE: clk_out=0.
//     - ch_en=1 -> RUN, cnt<=L, running=1 next cycle.
//     - The first flip (0->1) occurs L+1 cycles after entry.
//   - RUN:
//     - ch_en=0 with clk_out=0 -> IDLE immediately, cnt<=0.
//     - ch_en=0 with clk_out=1 -> STOPPING, keeps counting.
//   - STOPPING:
//     - At cnt==0, clk_out flips 1->0 and the state goes to IDLE; no further high phase is generated.
//     - ch_en=1 again before that -> back to RUN; count is undisturbed and no glitch is produced.
//  Simultaneous events:
//   - ch_en falls in the same cycle as a 0->1 flip -> flip happens, state goes to STOPPING.
//   - seed_load in a reload cycle -> reload uses the pre-load lfsr value.
//  High/low phase width is never < 1 cycle, so no glitches. Channels are fully independent apart from the shared LFSR.
//  rst_n low mid-operation -> all outputs 0 asynchronously, regardless of phase.
// TESTING
//  1. Reset held, toggle inputs -> clk_out/toggle_pls/running all 0. Release -> lfsr==16'hACE1.
//  2. ch0 hp=2, mask=0, en=1 -> clk_out[0] period exactly 6 cycles. First rise at cycle 3 after RUN entry.
//  3. hp=0, mask=0 -> clk/2 on every channel. hp=255, mask=8'hFF -> reload saturates at 255, interval 256 cycles.
//  4. ch_en dropped mid-high-phase -> high phase completes full length, then IDLE with clk_out=0, running=0.
//     Re-enable during STOPPING -> waveform continues uninterrupted.
//  5. seed_load seed=16'h1234, record 50 toggle intervals. Reload same seed -> identical sequence.
//     seed=0 -> behaves as SEED.
//  6. hp=4, mask=8'h03 over 1000 toggles -> every interval within [5,8], no phase <1 cycle.
//     Assert rst_n mid-run -> immediate zeros.

Source files
------------

// File: rtl/jitter_clk_gen.sv
// Multi-channel divided clock / enable generator with shared-LFSR jitter.
// Each channel counts down a reloadable half-period and flips its output at zero;
// start and stop are glitch-free because a high phase always runs to completion.
module jitter_clk_gen #(
  parameter int unsigned        N_CH   = 4,
  parameter int unsigned        CNT_W  = 8,
  parameter int unsigned        LFSR_W = 16,
  parameter logic [LFSR_W-1:0]  SEED   = 16'hACE1,
  parameter logic [LFSR_W-1:0]  TAPS   = 16'hB400
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [N_CH-1:0]       i_ch_en,
  input  logic [N_CH*CNT_W-1:0] i_half_period,
  input  logic [CNT_W-1:0]      i_jitter_mask,
  input  logic                  i_seed_load,
  input  logic [LFSR_W-1:0]     i_seed,
  output logic [N_CH-1:0]       o_clk_out,
  output logic [N_CH-1:0]       o_toggle_pls,
  output logic [N_CH-1:0]       o_running
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StRun  = 2'd1;
  localparam logic [1:0] StStop = 2'd2;

  logic [LFSR_W-1:0] r_lfsr;
  logic [LFSR_W-1:0] w_lfsr_shift;
  logic [LFSR_W-1:0] w_lfsr_nxt;

  // Galois right-shift step; a seed load overrides the shift, zero seed maps to SEED
  always_comb begin
    w_lfsr_shift = r_lfsr >> 1;
    if (r_lfsr[0]) w_lfsr_shift = w_lfsr_shift ^ TAPS;
    if (i_seed_load) begin
      w_lfsr_nxt = (i_seed == '0) ? SEED : i_seed;
    end else begin
      w_lfsr_nxt = w_lfsr_shift;
    end
  end

  // LFSR register, runs every cycle regardless of channel activity
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_lfsr <= SEED;
    else          r_lfsr <= w_lfsr_nxt;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    localparam int unsigned ROT = (3 * i) % LFSR_W;

    logic [CNT_W-1:0] w_rnd;
    logic [CNT_W:0]   w_sum;
    logic [CNT_W-1:0] w_reload;
    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_clk;
    logic             w_clk_nxt;
    logic             r_pls;
    logic             w_flip;

    // Low bits of the LFSR rotated left by 3*i: bit b comes from bit (b - ROT) mod LFSR_W
    for (genvar b = 0; b < CNT_W; b++) begin : g_rot
      assign w_rnd[b] = r_lfsr[(b + LFSR_W - ROT) % LFSR_W];
    end

    // Reload value: base half-period plus masked jitter, saturating at all-ones
    always_comb begin
      w_sum    = {1'b0, i_half_period[i*CNT_W +: CNT_W]} + {1'b0, w_rnd & i_jitter_mask};
      w_reload = w_sum[CNT_W] ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    // Channel FSM: count down, flip at zero, finish any high phase before going idle
    always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_clk_nxt   = r_clk;
      w_flip      = 1'b0;
      case (r_state)
        StIdle: begin
          w_clk_nxt = 1'b0;
          w_cnt_nxt = '0;
          if (i_ch_en[i]) begin
            w_state_nxt = StRun;
            w_cnt_nxt   = w_reload;
          end
        end
        StRun: begin
          if (r_cnt == '0) begin
            w_flip    = 1'b1;
            w_clk_nxt = ~r_clk;
            w_cnt_nxt = w_reload;
            if (!i_ch_en[i]) begin
              // Falling flip ends the waveform; rising flip must complete its high phase
              if (r_clk) begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
              end else begin
                w_state_nxt = StStop;
              end
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (!i_ch_en[i]) begin
              if (r_clk) begin
                w_state_nxt = StStop;
              end else begin
                w_state_nxt = StIdle;
                w_cnt_nxt   = '0;
              end
            end
          end
        end
        StStop: begin
          if (r_cnt == '0) begin
            w_flip    = 1'b1;
            w_clk_nxt = 1'b0;
            if (i_ch_en[i]) begin
              w_state_nxt = StRun;
              w_cnt_nxt   = w_reload;
            end else begin
              w_state_nxt = StIdle;
              w_cnt_nxt   = '0;
            end
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
            if (i_ch_en[i]) w_state_nxt = StRun;
          end
        end
        default: begin
          w_state_nxt = StIdle;
          w_cnt_nxt   = '0;
          w_clk_nxt   = 1'b0;
        end
      endcase
    end

    // Channel state registers; toggle pulse lags the flip by one cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_state <= StIdle;
        r_cnt   <= '0;
        r_clk   <= 1'b0;
        r_pls   <= 1'b0;
      end else begin
        r_state <= w_state_nxt;
        r_cnt   <= w_cnt_nxt;
        r_clk   <= w_clk_nxt;
        r_pls   <= w_flip;
      end
    end

    assign o_clk_out[i]    = r_clk;
    assign o_toggle_pls[i] = r_pls;
    assign o_running[i]    = (r_state != StIdle);
  end

endmodule
